// File: rtl/down_timer_if.sv
// Control/status bundle between a down_timer and whoever programs it.
// Carries the load/start/stop/mode controls and the count/running/expired status.
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;

    modport master (
        output load, load_value, start, stop, mode,
        input  count, running, expired
    );

    modport slave (
        input  load, load_value, start, stop, mode,
        output count, running, expired
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer, one-shot or periodic, with a one-cycle expired pulse.
// Latency: accepted start shows running next cycle; first decrement one edge later.
// Backpressure: none; controls are level-sampled every edge, reset > load > stop > start.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    down_timer_if.slave  bus
);
    localparam logic [0:0]       IDLE = 1'b0;
    localparam logic [0:0]       RUN  = 1'b1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             expired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
        end else if (bus.load) begin
            count_q   <= bus.load_value;
            reload_q  <= bus.load_value;
            state     <= IDLE;
            expired_q <= 1'b0;
        end else if (state == RUN) begin
            if (bus.stop) begin
                state     <= IDLE;
                expired_q <= 1'b0;
            end else if (count_q > ONE) begin
                count_q   <= count_q - ONE;
                expired_q <= 1'b0;
            end else if (count_q == ONE) begin
                count_q   <= '0;
                expired_q <= 1'b1;
                if (!mode_q) begin
                    state <= IDLE;
                end
            end else begin
                // Zero is only held for a cycle in periodic mode; reload is nonzero here.
                count_q   <= reload_q;
                expired_q <= 1'b0;
            end
        end else begin
            expired_q <= 1'b0;
            if (bus.start && !bus.stop && (count_q != '0)) begin
                state  <= RUN;
                mode_q <= bus.mode;
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state == RUN);
    assign bus.expired = expired_q;
endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with one-shot and periodic modes. It is the counterpart to the free-running up-counter: instead of counting up from zero, it counts down from a software-loaded value and flags terminal count. It sits beside the counter in the test/peripheral layer, and its `expired` pulse serves as a tick or timeout source for other blocks.

## Interface
- `WIDTH`, default 8: width of the count, load value and reload register.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `load`  input  1  load `load_value` into the count and reload registers; forces IDLE.
- `load_value`  input  WIDTH  value captured on `load`.
- `start`  input  1  begin or resume counting (IDLE -> RUN).
- `stop`  input  1  pause counting (RUN -> IDLE); the count is held.
- `mode`  input  1  0 = one-shot, 1 = periodic; sampled only on an accepted `start`.
- `count`  output  WIDTH  current count value (registered).
- `running`  output  1  high while in RUN.
- `expired`  output  1  one-cycle pulse marking terminal count (registered).

## Operation
- State: the 2-state FSM IDLE/RUN, plus `count`, `reload`, and `mode_q` (the latched mode).
- Reset values: state IDLE, `count` = 0, `reload` = 0, `mode_q` = 0, `running` = 0, `expired` = 0.
- Control priority per edge is `reset` > `load` > `stop` > `start`.
- `load`, in any state: `count` <= `load_value` and `reload` <= `load_value`. State goes to IDLE and `expired` goes to 0.
- `stop`, in RUN: go to IDLE with `count` held. `stop` in IDLE has no effect.
- `start`, in IDLE with `count` != 0: go to RUN and set `mode_q` <= `mode`. On this edge `count` is unchanged.
- `start` in IDLE with `count` == 0 is ignored; the block stays in IDLE. `start` in RUN is ignored, and `mode` is not re-sampled.
- Each RUN edge with no `load` or `stop` applies exactly one of these rules:
  - `count` > 1: `count` <= `count` - 1, `expired` <= 0.
  - `count` == 1: `count` <= 0 and `expired` <= 1. In one-shot (`mode_q` = 0), go to IDLE on the same edge.
  - `count` == 0 (reachable only in periodic): `count` <= `reload`, `expired` <= 0.
- `reload` >= 1 is guaranteed while in RUN: entry requires `count` != 0, and any load forces IDLE.
- In IDLE, `expired` <= 0 on every edge. It is therefore never high for more than one cycle.
- Arithmetic is unsigned, WIDTH bits. The count never decrements below 0 and never wraps.
- `running` is a direct decode of state RUN.

## Timing
- Start latency: `start` sampled at edge k puts `running` = 1 after edge k. The first decrement happens at edge k+1.
- One-shot, loaded with N >= 1: `count` shows N after edge k, then N-1 ... 0 at edges k+1 ... k+N.
  - At edge k+N, `expired` = 1 and `running` = 0 together.
  - After edge k+N+1, `expired` = 0.
- Periodic, loaded with N: the sequence is N, N-1, ..., 1, 0, N, ... with period N+1 cycles. `expired` is high exactly in the cycles where `count` = 0.
- Pause and resume preserve the count. The first decrement after resume happens one edge after the accepted `start`.
- Reset mid-RUN: after the reset edge, all outputs hold their reset values.
- `load` mid-RUN: after that edge, `count` = `load_value`, `running` = 0, and a new `start` is required.
- `load` on the same edge as the count == 1 terminal: `load` wins and no `expired` pulse is produced.
- `stop` on the same edge as the count == 1 terminal: `stop` wins. `count` holds 1 and no pulse is produced.

## Test plan
- One-shot: load 3, mode 0, start. Expect `count` 3, 2, 1, 0 on consecutive cycles; `expired` = 1 only in the cycle `count` = 0; `running` falls in that same cycle; the count then stays at 0.
- Periodic: load 2, mode 1, start, run 9 cycles. Expect `count` 2, 1, 0, 2, 1, 0, 2, 1, 0, with `expired` high at each 0. Toggling `mode` mid-run changes nothing.
- Pause: load 10, start, stop when `count` = 5. Expect `count` holds 5 with `running` = 0 for 4 cycles. After restart, 5 holds one cycle, then 4, 3, ...
- Edge controls:
  - Start with `count` = 0 (after reset or after load 0): expect `running` stays 0.
  - `start` and `stop` asserted together in IDLE: expect no entry to RUN.
  - Stop exactly when `count` = 1: expect no `expired` pulse.
- Override: load 200 and start; load 7 mid-run. Expect `count` = 7, `running` = 0. Assert reset mid-run: expect `count` = 0, `running` = 0, `expired` = 0 next cycle.
- Width: WIDTH = 4, load 15, one-shot. Expect 16 cycles from start to `expired` with no wrap. WIDTH = 8, load 255, periodic: expect period 256.
